// File: rtl/call_register.sv
// Floor-call front end for the elevator: syncs and debounces three active-low keys,
// latches accepted presses until served, blocks calls in SOS and flags stuck keys.
`timescale 1ns/1ps

module call_register #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STUCK_CYCLES    = 250000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] key_n,
    input  logic       sos_active,
    input  logic       served_valid,
    input  logic [1:0] served_floor,
    output logic [2:0] call_pending,
    output logic [2:0] call_pulse,
    output logic [2:0] stuck_fault
);
    localparam int NUM_KEYS = 3;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] HOLD_MAX  = SW'(STUCK_CYCLES);
    localparam logic [SW-1:0] HOLD_LAST = SW'(STUCK_CYCLES - 1);

    genvar g;
    generate
        for (g = 0; g < NUM_KEYS; g++) begin : g_key
            logic [1:0]    r_sync;
            logic          r_stable;
            logic          r_stable_d;
            logic [DW-1:0] r_db_cnt;
            logic [SW-1:0] r_hold_cnt;
            logic          r_stuck;
            logic          r_pending;
            logic          r_pulse;

            logic w_press;
            logic w_serve;
            logic w_db_done;
            logic w_stable_nxt;
            logic w_rise;
            logic w_stuck_set;
            logic w_accept;

            always_comb begin
                w_press      = ~r_sync[1];
                w_serve      = served_valid && (served_floor == 2'(g));
                w_db_done    = (w_press != r_stable) && (r_db_cnt == DB_LAST);
                w_stable_nxt = w_db_done ? ~r_stable : r_stable;
                w_rise       = r_stable & ~r_stable_d;
                // Stuck fires on the edge the hold count reaches its limit, only if still held.
                w_stuck_set  = r_stable & w_stable_nxt & (r_hold_cnt == HOLD_LAST);
                w_accept     = w_rise & ~sos_active & ~r_stuck & ~w_serve;
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync     <= 2'b11;
                    r_stable   <= 1'b0;
                    r_stable_d <= 1'b0;
                    r_db_cnt   <= '0;
                end else begin
                    r_sync     <= {r_sync[0], key_n[g]};
                    r_stable   <= w_stable_nxt;
                    r_stable_d <= r_stable;
                    if ((w_press == r_stable) || w_db_done)
                        r_db_cnt <= '0;
                    else
                        r_db_cnt <= r_db_cnt + DW'(1);
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_hold_cnt <= '0;
                    r_stuck    <= 1'b0;
                end else if (!w_stable_nxt) begin
                    r_hold_cnt <= '0;
                    r_stuck    <= 1'b0;
                end else if (r_stable && (r_hold_cnt != HOLD_MAX)) begin
                    r_hold_cnt <= r_hold_cnt + SW'(1);
                    if (w_stuck_set)
                        r_stuck <= 1'b1;
                end
            end

            // Clears (SOS, serve, new stuck fault) take priority over a fresh press.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_pending <= 1'b0;
                    r_pulse   <= 1'b0;
                end else begin
                    r_pulse <= w_accept;
                    if (sos_active || w_serve || w_stuck_set)
                        r_pending <= 1'b0;
                    else if (w_accept)
                        r_pending <= 1'b1;
                end
            end

            assign call_pending[g] = r_pending;
            assign call_pulse[g]   = r_pulse;
            assign stuck_fault[g]  = r_stuck;
        end
    endgenerate

endmodule

// File: tb/tb_call_register.sv
// Self-checking bench for call_register: directed scenarios with literal expectations,
// then randomized keys/SOS/serves compared every cycle against an edge-timestamp model.
`timescale 1ns/1ps

module tb_call_register;
    localparam int D = 4;
    localparam int S = 32;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] key_n = 3'b111;
    logic       sos_active = 1'b0;
    logic       served_valid = 1'b0;
    logic [1:0] served_floor = 2'd0;
    logic [2:0] call_pending;
    logic [2:0] call_pulse;
    logic [2:0] stuck_fault;

    int checks = 0;
    int failures = 0;
    logic [2:0] pulse_or = 3'b000;

    call_register #(.DEBOUNCE_CYCLES(D), .STUCK_CYCLES(S)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_n        (key_n),
        .sos_active   (sos_active),
        .served_valid (served_valid),
        .served_floor (served_floor),
        .call_pending (call_pending),
        .call_pulse   (call_pulse),
        .stuck_fault  (stuck_fault)
    );

    always #5 clk = ~clk;

    // Model: per key, remember the edge where the debounced input last agreed with the
    // stable state and the edge of the last stable press; everything else is arithmetic.
    logic [2:0] exp_pending, exp_pulse, exp_stuck, m_stable, d1, d2;
    int ecount;
    int agree_edge [3];
    int press_edge [3];
    logic m_p, m_serve, m_tog, m_nst, m_stuck_new, m_acc;

    task automatic model_reset();
        ecount      = 0;
        exp_pending = 3'b000;
        exp_pulse   = 3'b000;
        exp_stuck   = 3'b000;
        m_stable    = 3'b000;
        d1          = 3'b111;
        d2          = 3'b111;
        for (int k = 0; k < 3; k++) begin
            agree_edge[k] = 0;
            press_edge[k] = -100;
        end
    endtask

    task automatic model_step();
        ecount++;
        for (int k = 0; k < 3; k++) begin
            m_p     = ~d2[k];
            m_serve = served_valid && (int'(served_floor) == k);
            m_tog   = 1'b0;
            if (m_p == m_stable[k]) agree_edge[k] = ecount;
            else if (ecount - agree_edge[k] >= D) m_tog = 1'b1;
            m_nst       = m_stable[k] ^ m_tog;
            m_stuck_new = m_stable[k] && m_nst && (ecount - press_edge[k] == S);
            m_acc       = (press_edge[k] == ecount - 1) && !sos_active && !exp_stuck[k] && !m_serve;
            exp_pulse[k] = m_acc;
            if (sos_active || m_serve || m_stuck_new) exp_pending[k] = 1'b0;
            else if (m_acc) exp_pending[k] = 1'b1;
            exp_stuck[k] = m_nst && (exp_stuck[k] || m_stuck_new);
            if (m_tog) begin
                agree_edge[k] = ecount;
                if (m_nst) press_edge[k] = ecount;
            end
            m_stable[k] = m_nst;
        end
        d2 = d1;
        d1 = key_n;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (call_pending !== exp_pending) begin
                failures++;
                $display("FAIL model_pending t=%0t got %b want %b", $time, call_pending, exp_pending);
            end
            checks++;
            if (call_pulse !== exp_pulse) begin
                failures++;
                $display("FAIL model_pulse t=%0t got %b want %b", $time, call_pulse, exp_pulse);
            end
            checks++;
            if (stuck_fault !== exp_stuck) begin
                failures++;
                $display("FAIL model_stuck t=%0t got %b want %b", $time, stuck_fault, exp_stuck);
            end
        end
    end

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            pulse_or = pulse_or | call_pulse;
        end
    endtask

    int dur [3];
    int sos_dur;

    initial begin
        step(3);
        chk("reset_pending", call_pending, 3'b000);
        chk("reset_pulse", call_pulse, 3'b000);
        chk("reset_stuck", stuck_fault, 3'b000);
        reset_n = 1'b1;
        step(4);

        // basic press on floor 2, ignored floor-3 serve, then real serve
        key_n = 3'b101;
        step(6);
        chk("t1_pend_e6", call_pending, 3'b000);
        step(1);
        chk("t1_pend_e7", call_pending, 3'b010);
        chk("t1_pulse_e7", call_pulse, 3'b010);
        chk("t1_model_e7", exp_pending, 3'b010);
        step(1);
        chk("t1_pulse_e8", call_pulse, 3'b000);
        chk("t1_pend_e8", call_pending, 3'b010);
        step(12);
        key_n = 3'b111;
        step(10);
        served_valid = 1'b1;
        served_floor = 2'd3;
        step(1);
        chk("t1_floor3", call_pending, 3'b010);
        served_floor = 2'd1;
        step(1);
        chk("t1_serve", call_pending, 3'b000);
        served_valid = 1'b0;

        // glitch rejection
        pulse_or = 3'b000;
        key_n = 3'b110; step(3);
        key_n = 3'b111; step(1);
        key_n = 3'b110; step(3);
        key_n = 3'b111; step(8);
        chk("t2_no_pulse", pulse_or, 3'b000);
        chk("t2_pend", call_pending, 3'b000);

        // press/serve collision on floor 3
        key_n = 3'b011;
        step(6);
        served_valid = 1'b1;
        served_floor = 2'd2;
        step(1);
        chk("t3_pend", call_pending, 3'b000);
        chk("t3_pulse", call_pulse, 3'b000);
        served_valid = 1'b0;
        step(1);
        chk("t3_pulse_after", call_pulse, 3'b000);
        key_n = 3'b111;
        step(10);

        // SOS clears and blocks; held key not re-accepted after exit
        key_n = 3'b100;
        step(7);
        chk("t4_pend", call_pending, 3'b011);
        sos_active = 1'b1;
        step(1);
        chk("t4_sos_clear", call_pending, 3'b000);
        key_n = 3'b111;
        step(10);
        pulse_or = 3'b000;
        key_n = 3'b011;
        step(10);
        sos_active = 1'b0;
        step(5);
        chk("t4_sos_no_pulse", pulse_or, 3'b000);
        chk("t4_held_exit", call_pending, 3'b000);
        key_n = 3'b111;
        step(8);
        key_n = 3'b011;
        step(7);
        chk("t4_repress", call_pending, 3'b100);
        chk("t4_repress_pulse", call_pulse, 3'b100);
        key_n = 3'b111;
        served_valid = 1'b1;
        served_floor = 2'd2;
        step(1);
        served_valid = 1'b0;
        chk("t4_serve", call_pending, 3'b000);
        step(8);

        // stuck key on floor 3
        key_n = 3'b011;
        step(7);
        chk("t5_pend", call_pending, 3'b100);
        step(30);
        chk("t5_stuck_e37", stuck_fault, 3'b000);
        chk("t5_pend_e37", call_pending, 3'b100);
        step(1);
        chk("t5_stuck_e38", stuck_fault, 3'b100);
        chk("t5_pend_e38", call_pending, 3'b000);
        step(22);
        key_n = 3'b111;
        step(5);
        chk("t5_stuck_hold", stuck_fault, 3'b100);
        step(1);
        chk("t5_stuck_rel", stuck_fault, 3'b000);
        step(5);

        // async reset mid-debounce, key 0 held through release
        key_n = 3'b010;
        step(7);
        chk("t6_pend", call_pending, 3'b101);
        key_n = 3'b000;
        step(3);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_pend", call_pending, 3'b000);
        chk("t6_rst_pulse", call_pulse, 3'b000);
        chk("t6_rst_stuck", stuck_fault, 3'b000);
        key_n = 3'b110;
        step(2);
        reset_n = 1'b1;
        step(6);
        chk("t6_pend_e6", call_pending, 3'b000);
        step(1);
        chk("t6_pend_e7", call_pending, 3'b001);
        chk("t6_pulse_e7", call_pulse, 3'b001);
        key_n = 3'b111;
        step(10);

        // randomized traffic, checked every cycle by the model
        for (int k = 0; k < 3; k++) dur[k] = 0;
        sos_dur = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (dur[k] == 0) begin
                    key_n[k] = ~key_n[k];
                    if (key_n[k] == 1'b0)
                        dur[k] = ($urandom_range(0, 19) == 0) ? 45 : int'($urandom_range(1, 10));
                    else
                        dur[k] = int'($urandom_range(1, 10));
                end else begin
                    dur[k]--;
                end
            end
            if (sos_dur == 0) begin
                sos_active = ($urandom_range(0, 9) == 0);
                sos_dur = int'($urandom_range(3, 30));
            end else begin
                sos_dur--;
            end
            served_valid = ($urandom_range(0, 5) == 0);
            served_floor = 2'($urandom_range(0, 3));
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/call_register.md
# call_register

Upstream stage for the elevator `movement` block. It takes the three raw active-low floor-call keys, synchronizes and debounces them, and detects presses. It latches each accepted press as a pending call until `movement` reports that floor served. It also blocks calls during SOS and flags keys held down abnormally long.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to change a key's debounced state (10 ms at 50 MHz); legal range ≥1.
- `STUCK_CYCLES`, default 250000000: cycles a debounced press may persist before it is declared stuck (5 s at 50 MHz); legal range > `DEBOUNCE_CYCLES`.

Ports:
- `clk`  in  1  system clock; all state is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `key_n`  in  3  raw board keys, active-low, asynchronous; bit i = floor i+1.
- `sos_active`  in  1  emergency mode level from `emergency`.
- `served_valid`  in  1  door open at `served_floor` this cycle.
- `served_floor`  in  2  served floor index: 0, 1 or 2 (floors 1–3); value 3 is ignored.
- `call_pending`  out  3  latched outstanding calls; drives `led1`..`led3` and `movement`.
- `call_pulse`  out  3  one-cycle strobe per accepted new call.
- `stuck_fault`  out  3  key i currently held beyond `STUCK_CYCLES`.

## Operation
- **Synchronizer:** per key, a 2-flop synchronizer on `key_n`.
  - Flops reset to 1 (released).
  - Internal press = inverted synchronized value.
- **Debouncer:** per key, a stable-state bit (reset 0 = released) and a counter of width `$clog2(DEBOUNCE_CYCLES+1)` (reset 0).
  - While the synchronized press equals the stable state, the counter holds 0.
  - While they differ, the counter increments every cycle.
  - On the `DEBOUNCE_CYCLES`-th consecutive differing edge, the stable state toggles and the counter returns to 0.
  - Any single cycle of agreement resets the counter, so glitches shorter than `DEBOUNCE_CYCLES` are rejected.
- **Press event:** the stable state going 0→1.
- **Acceptance:** a press event on key i is accepted only if `sos_active`=0, `stuck_fault[i]`=0, and key i's floor is not being served this same cycle.
  - Acceptance sets `call_pending[i]` and pulses `call_pulse[i]` for exactly one cycle.
  - A press on an already-pending floor still pulses `call_pulse`; `call_pending` stays 1.
- **Clear:** `served_valid`=1 with `served_floor`=i clears `call_pending[i]` at the next edge.
  - Simultaneous press event and serve on the same floor: serve wins; pending goes to 0 and there is no pulse.
- **SOS:** while `sos_active`=1, all `call_pending` bits clear at the next edge and all press events are discarded (no pulse).
  - The debouncers keep running, so a key held across SOS exit is not re-accepted until it is released and pressed again.
- **Stuck detection:** per key, a hold counter of width `$clog2(STUCK_CYCLES+1)`, saturating.
  - It counts while the stable state is pressed.
  - When it reaches `STUCK_CYCLES`, `stuck_fault[i]` sets and `call_pending[i]` clears at that same edge.
  - A stable release clears the counter and `stuck_fault[i]` at the release edge.
- **Floor independence:** each floor is handled independently; any combination of simultaneous events on different floors is handled in parallel.

## Timing
- **Reset:** while `reset_n`=0, `call_pending`, `call_pulse` and `stuck_fault` are 0, all counters are 0, stable states are released and synchronizers are 1.
  - Reset asserted mid-debounce or mid-hold discards the partial count.
  - A key held through reset release must still debounce from zero; the first acceptance follows the full press latency.
- **Press latency:** let edge 1 be the first edge sampling `key_n`=0 with the key held steadily.
  - The stable state toggles at edge `DEBOUNCE_CYCLES`+2.
  - `call_pending[i]` rises and `call_pulse[i]` is high for the cycle following edge `DEBOUNCE_CYCLES`+3.
- **Release latency:** mirrors press latency; there is no output change on release unless `stuck_fault` was set.
- **Clear latency:** one edge from `served_valid`/`sos_active` to `call_pending` falling.
- **Stuck latency:** `stuck_fault` rises `STUCK_CYCLES` edges after the stable-state press edge.
- **Output registration:** all outputs are registered with no combinational input-to-output path.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `STUCK_CYCLES`=32.
1. **Basic press:** reset, then hold `key_n[1]`=0 for 20 cycles → `call_pending`=3'b010 and `call_pulse[1]` high for 1 cycle, both beginning after edge 7. Then `served_valid`=1, `served_floor`=1 for 1 cycle → `call_pending`=0 one edge later.
2. **Glitch rejection:** `key_n[0]` low for 3 cycles, high 1, low 3 → no pulse and `call_pending`=0 throughout.
3. **Press/serve collision:** press event on key 2 in the same cycle as `served_valid`=1 with `served_floor`=2 → `call_pending[2]`=0 and no `call_pulse`. Also `served_floor`=3 → no effect.
4. **SOS:** `call_pending`=3'b011, then raise `sos_active` → 0 next edge. A press during SOS gives no pulse. After SOS exits, release and re-press → accepted.
5. **Stuck key:** hold `key_n[2]` for 60 cycles → pending sets after edge 7, then `stuck_fault[2]`=1 and pending clears 32 edges after the stable press. Release → `stuck_fault` clears once the debounced release takes effect.
6. **Async reset mid-operation:** assert `reset_n`=0 mid-debounce with pending=3'b101 → all outputs 0 immediately. Deassert with key 0 still held → accepted after the full press latency.
